counter_updown_param: RTL and testbench

//   Parametrised synchronous up/down counter; next generation of the 3-bit up/down counter.

---
 rtl/counter_updown_param.sv | 103 ++++++++++
 tb/tb_counter_updown_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with wrap/saturate, load,
// terminal count, wrap pulse and Gray-coded output.
module counter_updown_param #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);
  localparam bit FULL = (MODULUS == (2 ** WIDTH));

  if (WIDTH < 1 || MODULUS < 2 ||
      MODULUS > (2 ** WIDTH)) begin : g_bad_cfg
    $error("counter_updown_param: bad WIDTH/MODULUS");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;
  logic             cnt_oor;
  logic             ld_oor;
  logic [WIDTH-1:0] ld_val;

  assign at_max  = (count_q == MAX);
  assign at_zero = (count_q == '0);

  // Range checks vanish when the modulus fills the width.
  if (FULL) begin : g_full
    assign cnt_oor = 1'b0;
    assign ld_oor  = 1'b0;
  end else begin : g_part
    assign cnt_oor = (count_q > MAX);
    assign ld_oor  = (load_value > MAX);
  end

  assign ld_val = ld_oor ? MAX : load_value;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    priority case (1'b1)
      !reset: begin
        count_d = '0;
      end
      load: begin
        count_d = ld_val;
      end
      en && mode: begin
        if (cnt_oor) begin
          count_d = '0;
        end else if (at_max) begin
          if (!SATURATE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      en && !mode: begin
        if (cnt_oor) begin
          count_d = MAX;
        end else if (at_zero) begin
          if (!SATURATE) begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign gray  = count_q ^ (count_q >> 1);
  assign tc    = mode ? at_max : at_zero;

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: three configurations
// driven together, checked against an arithmetic model.
module tb_counter_updown_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = '0;

  logic [2:0] c8, g8, c6, g6, c6s, g6s;
  logic       t8, w8, t6, w6, t6s, w6s;

  counter_updown_param #(
    .WIDTH(3), .MODULUS(8), .SATURATE(1'b0)
  ) u8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_value(load_value),
    .count(c8), .gray(g8), .tc(t8), .wrap(w8)
  );

  counter_updown_param #(
    .WIDTH(3), .MODULUS(6), .SATURATE(1'b0)
  ) u6 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_value(load_value),
    .count(c6), .gray(g6), .tc(t6), .wrap(w6)
  );

  counter_updown_param #(
    .WIDTH(3), .MODULUS(6), .SATURATE(1'b1)
  ) u6s (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_value(load_value),
    .count(c6s), .gray(g6s), .tc(t6s), .wrap(w6s)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  int mod_t[3] = '{8, 6, 6};
  bit sat_t[3] = '{1'b0, 1'b0, 1'b1};
  int mc[3] = '{0, 0, 0};
  bit mw[3] = '{1'b0, 1'b0, 1'b0};

  function automatic int m_next(
    int m, bit sat, int c, bit r, bit ld,
    int lv, bit e, bit md);
    if (!r) return 0;
    if (ld) return (lv > m - 1) ? m - 1 : lv;
    if (!e) return c;
    if (md) begin
      if (c > m - 1) return 0;
      if (c == m - 1) return sat ? c : 0;
      return c + 1;
    end
    if (c > m - 1) return m - 1;
    if (c == 0) return sat ? 0 : m - 1;
    return c - 1;
  endfunction

  function automatic bit m_wrap(
    int m, bit sat, int c, bit r, bit ld,
    bit e, bit md);
    if (!r || ld || !e || sat) return 1'b0;
    if (c > m - 1) return 1'b0;
    return md ? (c == m - 1) : (c == 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mc[i] <= m_next(mod_t[i], sat_t[i], mc[i],
                      reset, load, int'(load_value),
                      en, mode);
      mw[i] <= m_wrap(mod_t[i], sat_t[i], mc[i],
                      reset, load, en, mode);
    end
  end

  logic [2:0] dc[3], dg[3];
  logic       dt[3], dw[3];
  assign dc[0] = c8;  assign dg[0] = g8;
  assign dt[0] = t8;  assign dw[0] = w8;
  assign dc[1] = c6;  assign dg[1] = g6;
  assign dt[1] = t6;  assign dw[1] = w6;
  assign dc[2] = c6s; assign dg[2] = g6s;
  assign dt[2] = t6s; assign dw[2] = w6s;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        int ec;
        ec = mc[i];
        chk($sformatf("count[%0d]", i), int'(dc[i]), ec);
        chk($sformatf("wrap[%0d]", i), int'(dw[i]),
            int'(mw[i]));
        chk($sformatf("gray[%0d]", i), int'(dg[i]),
            ec ^ (ec >> 1));
        chk($sformatf("tc[%0d]", i), int'(dt[i]),
            mode ? int'(ec == mod_t[i] - 1)
                 : int'(ec == 0));
      end
    end
  end

  task automatic drive(input bit r, input bit e,
                       input bit m, input bit l,
                       input int lv);
    #1;
    reset = r;
    en = e;
    mode = m;
    load = l;
    load_value = 3'(lv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  initial begin
    // Reset state, mode=0 so tc must be high.
    drive(0, 1, 0, 1, 5);
    tick(1);
    chk_on = 1'b1;
    chk("rst_count", int'(c8), 0);
    chk("rst_wrap", int'(w8), 0);
    chk("rst_gray", int'(g8), 0);
    chk("rst_tc", int'(t8), 1);

    // Up-count mod 8 from reset.
    drive(1, 1, 1, 0, 0);
    tick(7);
    chk("up8_at7", int'(c8), 7);
    chk("up8_tc7", int'(t8), 1);
    chk("up8_gray7", int'(g8), 4);
    tick(1);
    chk("up8_wrap0", int'(c8), 0);
    chk("up8_wrap_p", int'(w8), 1);
    tick(1);
    chk("up8_one", int'(c8), 1);
    chk("up8_wrap_off", int'(w8), 0);

    // Down-count mod 6 from reset.
    drive(0, 0, 0, 0, 0);
    tick(1);
    drive(1, 1, 0, 0, 0);
    tick(1);
    chk("dn6_first", int'(c6), 5);
    chk("dn6_wrap", int'(w6), 1);
    chk("dn6s_hold", int'(c6s), 0);
    chk("dn6s_tc", int'(t6s), 1);
    tick(5);
    chk("dn6_zero", int'(c6), 0);
    tick(1);
    chk("dn6_again", int'(c6), 5);

    // Saturating up-count stops at 5.
    drive(0, 0, 1, 0, 0);
    tick(1);
    drive(1, 1, 1, 0, 0);
    tick(8);
    chk("sat_hold", int'(c6s), 5);
    chk("sat_tc", int'(t6s), 1);
    chk("sat_nowrap", int'(w6s), 0);

    // Load, clamp, load beats en.
    drive(1, 1, 1, 1, 3);
    tick(1);
    chk("ld3", int'(c6), 3);
    drive(1, 1, 1, 1, 7);
    tick(1);
    chk("ld7_clamp6", int'(c6), 5);
    chk("ld7_m8", int'(c8), 7);
    chk("ld_nowrap", int'(w8), 0);

    // Reset overrides concurrent load/en.
    drive(1, 1, 1, 1, 0);
    tick(1);
    drive(1, 1, 1, 0, 0);
    tick(4);
    chk("to4", int'(c8), 4);
    drive(0, 1, 1, 1, 6);
    tick(1);
    chk("rst_ovr", int'(c8), 0);
    chk("rst_ovr_w", int'(w8), 0);
    drive(1, 1, 1, 0, 0);
    tick(1);
    chk("resume", int'(c8), 1);

    // Gray sequence and mode toggle at 4.
    drive(0, 0, 1, 0, 0);
    tick(1);
    chk("gray_0", int'(g8), gray_tab[0]);
    drive(1, 1, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("gray_%0d", k), int'(g8),
          gray_tab[k]);
    end
    drive(1, 1, 0, 0, 0);
    tick(1);
    chk("toggle_3", int'(c8), 3);
    tick(1);
    chk("toggle_2", int'(c8), 2);
    tick(1);
    chk("toggle_1", int'(c8), 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 39) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 7) < 5,
            $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 7)));
      tick(1);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
